edge_pool_capture: RTL

// - Consumer end of the edge-filter pixel stream: takes filtered 12-bit magnitudes (raster, one per iDVAL).
// - Captures one full frame per request, box-pools POOL_W x POOL_H tiles to their mean and writes
//   the OUT_W x OUT_H result into the NN input RAM.
// - Sits between the Sobel stage and the network core. Start/busy/done handshake on the NN side.

---
 rtl/pool_pkg.sv | 19 +
 rtl/pool_row_accum.sv | 33 +++
 rtl/edge_pool_capture.sv | 121 ++++++++++++
 3 files changed

// File: rtl/pool_pkg.sv
// pool_pkg: shared geometry, widths and capture states for the edge pooling block
package pool_pkg;
    localparam int IMG_W  = 640;
    localparam int IMG_H  = 480;
    localparam int POOL_W = 16;
    localparam int POOL_H = 16;
    localparam int OUT_W  = IMG_W / POOL_W;
    localparam int OUT_H  = IMG_H / POOL_H;
    localparam int DATA_W = 12;
    localparam int SHIFT  = $clog2(POOL_W * POOL_H);
    localparam int ACC_W  = DATA_W + SHIFT;
    localparam int ADDR_W = $clog2(OUT_W * OUT_H);

    typedef enum logic [1:0] {IDLE, WAIT_SOF, CAPTURE, DONE} cap_state_t;

    function automatic int cw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/pool_row_accum.sv
// pool_row_accum: one running tile sum per tile column, one read/modify/write per cycle
module pool_row_accum
    import pool_pkg::*;
#(
    parameter int DEPTH = OUT_W,
    parameter int AW    = ACC_W,
    parameter int IW    = cw(DEPTH)
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic [IW-1:0]     index,
    input  logic [DATA_W-1:0] add_val,
    input  logic              add_en,
    input  logic              clear_en,
    input  logic              clear_all,
    output logic [AW-1:0]     rd_data
);
    logic [AW-1:0] acc_q [DEPTH];
    logic [AW-1:0] acc_d [DEPTH];

    // clear_all drops every sum, yet the same beat may still seed the indexed entry
    always_comb begin
        for (int i = 0; i < DEPTH; i++) acc_d[i] = clear_all ? '0 : acc_q[i];
        if (clear_en) acc_d[index] = '0;
        else if (add_en) acc_d[index] = acc_d[index] + AW'(add_val);
    end

    assign rd_data = acc_q[index];

    always_ff @(posedge iCLK or negedge iRST)
        if (!iRST) acc_q <= '{default: '0};
        else acc_q <= acc_d;
endmodule

// File: rtl/edge_pool_capture.sv
// edge_pool_capture: captures one frame per request and writes box-pooled tile means to the NN RAM
module edge_pool_capture
    import pool_pkg::*;
#(
    parameter int IMG_W  = pool_pkg::IMG_W,
    parameter int IMG_H  = pool_pkg::IMG_H,
    parameter int POOL_W = pool_pkg::POOL_W,
    parameter int POOL_H = pool_pkg::POOL_H,
    parameter int OUT_W  = IMG_W / POOL_W,
    parameter int OUT_H  = IMG_H / POOL_H,
    parameter int ADDR_W = cw(OUT_W * OUT_H)
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic              iDVAL,
    input  logic [11:0]       iDATA,
    input  logic              iSOF,
    input  logic              iSTART,
    output logic              oBUSY,
    output logic              oDONE,
    output logic              oSYNC_ERR,
    output logic              oWR_EN,
    output logic [ADDR_W-1:0] oWR_ADDR,
    output logic [11:0]       oWR_DATA
);
    localparam int SHIFT = $clog2(POOL_W * POOL_H);
    localparam int ACC_W = 12 + SHIFT;
    localparam int XW    = cw(POOL_W);
    localparam int YW    = cw(POOL_H);
    localparam int TXW   = cw(OUT_W);
    localparam int TYW   = cw(OUT_H);
    localparam logic [XW-1:0]     X_LAST  = XW'(POOL_W - 1);
    localparam logic [YW-1:0]     Y_LAST  = YW'(POOL_H - 1);
    localparam logic [TXW-1:0]    TX_LAST = TXW'(OUT_W - 1);
    localparam logic [TYW-1:0]    TY_LAST = TYW'(OUT_H - 1);
    localparam logic [ADDR_W-1:0] A_LAST  = ADDR_W'(OUT_W * OUT_H - 1);

    cap_state_t        state_q, state_d;
    logic [XW-1:0]     sub_x_q, sub_x_d, bx;
    logic [YW-1:0]     sub_y_q, sub_y_d, by;
    logic [TXW-1:0]    tx_q, tx_d, btx;
    logic [TYW-1:0]    ty_q, ty_d, bty;
    logic              wr_en_q, wr_en_d, sync_err_q, sync_err_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [11:0]       wr_data_q, wr_data_d;
    logic [ACC_W-1:0]  rd_data, sum;
    logic              last_wr, restart, take, x_end, y_end, tx_end, ty_end, tile_done;

    pool_row_accum #(.DEPTH(OUT_W), .AW(ACC_W), .IW(TXW)) u_accum (
        .iCLK      (iCLK),
        .iRST      (iRST),
        .index     (btx),
        .add_val   (iDATA),
        .add_en    (take),
        .clear_en  (tile_done),
        .clear_all (restart),
        .rd_data   (rd_data)
    );

    // A restarting beat is processed as pixel (0,0) from zeroed counters and sums
    always_comb begin
        last_wr    = wr_en_q && wr_addr_q == A_LAST;
        restart    = iDVAL && iSOF && (state_q == WAIT_SOF || (state_q == CAPTURE && !last_wr));
        take       = restart || (iDVAL && state_q == CAPTURE && !last_wr);
        bx         = restart ? '0 : sub_x_q;
        by         = restart ? '0 : sub_y_q;
        btx        = restart ? '0 : tx_q;
        bty        = restart ? '0 : ty_q;
        x_end      = bx == X_LAST;
        y_end      = by == Y_LAST;
        tx_end     = btx == TX_LAST;
        ty_end     = bty == TY_LAST;
        tile_done  = take && x_end && y_end;
        sum        = (restart ? '0 : rd_data) + ACC_W'(iDATA);
        sub_x_d    = take ? (x_end ? '0 : bx + XW'(1)) : sub_x_q;
        tx_d       = (take && x_end) ? (tx_end ? '0 : btx + TXW'(1)) : btx;
        sub_y_d    = (take && x_end && tx_end) ? (y_end ? '0 : by + YW'(1)) : by;
        ty_d       = (take && x_end && tx_end && y_end) ? (ty_end ? '0 : bty + TYW'(1)) : bty;
        wr_en_d    = tile_done;
        wr_addr_d  = tile_done ? ADDR_W'(bty) * ADDR_W'(OUT_W) + ADDR_W'(btx) : wr_addr_q;
        wr_data_d  = tile_done ? sum[ACC_W-1:SHIFT] : wr_data_q;
        sync_err_d = restart && state_q == CAPTURE;
        state_d    = state_q;
        case (state_q)
            IDLE:     if (iSTART) state_d = WAIT_SOF;
            WAIT_SOF: if (restart) state_d = CAPTURE;
            CAPTURE:  if (last_wr) state_d = DONE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge iCLK or negedge iRST)
        if (!iRST) begin
            state_q    <= IDLE;
            sub_x_q    <= '0;
            sub_y_q    <= '0;
            tx_q       <= '0;
            ty_q       <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            sync_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sub_x_q    <= sub_x_d;
            sub_y_q    <= sub_y_d;
            tx_q       <= tx_d;
            ty_q       <= ty_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            sync_err_q <= sync_err_d;
        end

    assign oBUSY     = state_q == WAIT_SOF || state_q == CAPTURE;
    assign oDONE     = state_q == DONE;
    assign oSYNC_ERR = sync_err_q;
    assign oWR_EN    = wr_en_q;
    assign oWR_ADDR  = wr_addr_q;
    assign oWR_DATA  = wr_data_q;
endmodule
